// File: rtl/mac_learn_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mac_learn_ctrl_pkg
//   Shared definitions for the MAC learning/lookup sequencer:
//   - state_t        : sequencer state encoding
//   - MULTICAST_BIT  : I/G bit position (LSB of first octet) in a 48-bit MAC
//   - is_multicast() : true for group addresses, broadcast included
// ----------------------------------------------------------------------------
package mac_learn_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SRC_CMP,
        ST_SRC_EVAL,
        ST_LEARN,
        ST_WAIT_WR,
        ST_DST_CMP,
        ST_DST_EVAL,
        ST_RESP,
        ST_FLUSH
    } state_t;

    localparam int unsigned MULTICAST_BIT = 40;

    function automatic logic is_multicast(input logic [47:0] mac);
        return mac[MULTICAST_BIT];
    endfunction

endpackage

// File: rtl/mac_learn_ctrl_port_table.sv
// ----------------------------------------------------------------------------
// mac_port_table
//   2**ADDR_WIDTH x PORT_WIDTH port table indexed by CAM address.
//   One synchronous write port, one asynchronous read port. Contents are
//   not reset; an entry is only read after its CAM slot has been learned.
// Ports:
//   clk    : clock
//   we     : write enable
//   waddr  : write address
//   wdata  : port number to store
//   raddr  : read address (CAM match address)
//   rdata  : stored port number, combinational
// ----------------------------------------------------------------------------
module mac_port_table #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned PORT_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [PORT_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [PORT_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [PORT_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mac_learn_ctrl.sv
// ----------------------------------------------------------------------------
// mac_learn_ctrl
//   Learning/lookup sequencer placed in front of cam_bram. For every frame
//   header it looks up the source MAC (learning it or refreshing its port
//   binding), then looks up the destination MAC and answers with the egress
//   port, a flood or a drop. Also sequences a full-table flush.
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   req_*                     : header request (valid/ready), src/dst MAC,
//                               ingress port
//   resp_*                    : response (valid/ready), egress port, flood,
//                               drop
//   flush / flush_busy        : flush request pulse / flush pending or active
//   cam_write_*               : write/delete port towards cam_bram
//   cam_compare_data          : lookup key towards cam_bram
//   cam_match, cam_match_addr : lookup result, CAM_LAT cycles after the key
// ----------------------------------------------------------------------------
module mac_learn_ctrl
    import mac_learn_ctrl_pkg::*;
#(
    parameter int unsigned MAC_WIDTH  = 48,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned PORT_WIDTH = 2,
    parameter int unsigned CAM_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [MAC_WIDTH-1:0]  req_src_mac,
    input  logic [MAC_WIDTH-1:0]  req_dst_mac,
    input  logic [PORT_WIDTH-1:0] req_port,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [PORT_WIDTH-1:0] resp_port,
    output logic                  resp_flood,
    output logic                  resp_drop,
    input  logic                  flush,
    output logic                  flush_busy,
    output logic [ADDR_WIDTH-1:0] cam_write_addr,
    output logic [MAC_WIDTH-1:0]  cam_write_data,
    output logic                  cam_write_delete,
    output logic                  cam_write_enable,
    input  logic                  cam_write_busy,
    output logic [MAC_WIDTH-1:0]  cam_compare_data,
    input  logic                  cam_match,
    input  logic [ADDR_WIDTH-1:0] cam_match_addr
);

    localparam int unsigned LAT_W = $clog2(CAM_LAT + 1);

    state_t                state;
    logic [MAC_WIDTH-1:0]  src_q;
    logic [MAC_WIDTH-1:0]  dst_q;
    logic [PORT_WIDTH-1:0] port_q;
    logic [ADDR_WIDTH-1:0] alloc_ptr;
    logic [ADDR_WIDTH:0]   flush_cnt;   // MSB set once every entry has been deleted
    logic                  flush_pend;
    logic [LAT_W-1:0]      lat_cnt;
    logic                  wr_skip;     // cycle in which busy still reflects the pre-pulse state
    logic                  out_en;      // keeps req_ready low while in reset

    logic                  src_mc;
    logic                  dst_mc;
    logic                  port_moved;
    logic                  tbl_we;
    logic [ADDR_WIDTH-1:0] tbl_waddr;
    logic [PORT_WIDTH-1:0] tbl_wdata;
    logic [PORT_WIDTH-1:0] tbl_rdata;

    assign src_mc     = is_multicast(src_q);
    assign dst_mc     = is_multicast(dst_q);
    assign req_ready  = out_en && (state == ST_IDLE) && !flush_pend && !cam_write_busy;
    assign flush_busy = flush_pend || (state == ST_FLUSH);

    // Known station seen on a different ingress port: rebind in place.
    assign port_moved = (state == ST_SRC_EVAL) && !src_mc && cam_match &&
                        (tbl_rdata != port_q);

    always_comb begin
        tbl_we    = 1'b0;
        tbl_waddr = '0;
        tbl_wdata = '0;
        if (port_moved) begin
            tbl_we    = 1'b1;
            tbl_waddr = cam_match_addr;
            tbl_wdata = port_q;
        end else if ((state == ST_LEARN) && !cam_write_busy) begin
            tbl_we    = 1'b1;
            tbl_waddr = alloc_ptr;
            tbl_wdata = port_q;
        end
    end

    mac_port_table #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .PORT_WIDTH (PORT_WIDTH)
    ) u_port_table (
        .clk   (clk),
        .we    (tbl_we),
        .waddr (tbl_waddr),
        .wdata (tbl_wdata),
        .raddr (cam_match_addr),
        .rdata (tbl_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            src_q            <= '0;
            dst_q            <= '0;
            port_q           <= '0;
            alloc_ptr        <= '0;
            flush_cnt        <= '0;
            flush_pend       <= 1'b0;
            lat_cnt          <= '0;
            wr_skip          <= 1'b0;
            out_en           <= 1'b0;
            resp_valid       <= 1'b0;
            resp_port        <= '0;
            resp_flood       <= 1'b0;
            resp_drop        <= 1'b0;
            cam_write_addr   <= '0;
            cam_write_data   <= '0;
            cam_write_delete <= 1'b0;
            cam_write_enable <= 1'b0;
            cam_compare_data <= '0;
        end else begin
            out_en           <= 1'b1;
            cam_write_enable <= 1'b0;

            if ((state == ST_IDLE) && flush_pend) begin
                flush_pend <= 1'b0;
            end else if (flush && (state != ST_FLUSH)) begin
                flush_pend <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (flush_pend) begin
                        flush_cnt <= '0;
                        wr_skip   <= 1'b0;
                        state     <= ST_FLUSH;
                    end else if (req_valid && req_ready) begin
                        src_q            <= req_src_mac;
                        dst_q            <= req_dst_mac;
                        port_q           <= req_port;
                        cam_compare_data <= req_src_mac;
                        lat_cnt          <= LAT_W'(1);
                        state            <= ST_SRC_CMP;
                    end
                end

                ST_SRC_CMP: begin
                    if (lat_cnt == LAT_W'(CAM_LAT)) begin
                        state <= ST_SRC_EVAL;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end

                ST_SRC_EVAL: begin
                    if (!src_mc && !cam_match) begin
                        state <= ST_LEARN;
                    end else begin
                        lat_cnt <= '0;
                        state   <= ST_DST_CMP;
                    end
                end

                ST_LEARN: begin
                    if (!cam_write_busy) begin
                        cam_write_enable <= 1'b1;
                        cam_write_addr   <= alloc_ptr;
                        cam_write_data   <= src_q;
                        cam_write_delete <= 1'b0;
                        alloc_ptr        <= alloc_ptr + 1'b1;
                        wr_skip          <= 1'b1;
                        state            <= ST_WAIT_WR;
                    end
                end

                ST_WAIT_WR: begin
                    if (wr_skip) begin
                        wr_skip <= 1'b0;
                    end else if (!cam_write_busy) begin
                        lat_cnt <= '0;
                        state   <= ST_DST_CMP;
                    end
                end

                // lat_cnt==0 is the decision cycle; the key is launched there
                // so a multicast destination never reaches the CAM.
                ST_DST_CMP: begin
                    if (lat_cnt == '0) begin
                        if (dst_mc) begin
                            resp_valid <= 1'b1;
                            resp_flood <= 1'b1;
                            resp_drop  <= 1'b0;
                            resp_port  <= '0;
                            state      <= ST_RESP;
                        end else begin
                            cam_compare_data <= dst_q;
                            lat_cnt          <= LAT_W'(1);
                        end
                    end else if (lat_cnt == LAT_W'(CAM_LAT)) begin
                        state <= ST_DST_EVAL;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end

                ST_DST_EVAL: begin
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                    if (!cam_match) begin
                        resp_flood <= 1'b1;
                        resp_drop  <= 1'b0;
                        resp_port  <= '0;
                    end else begin
                        resp_flood <= 1'b0;
                        resp_port  <= tbl_rdata;
                        resp_drop  <= (tbl_rdata == port_q);
                    end
                end

                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end

                ST_FLUSH: begin
                    if (wr_skip) begin
                        wr_skip <= 1'b0;
                    end else if (!cam_write_busy) begin
                        if (flush_cnt[ADDR_WIDTH]) begin
                            alloc_ptr <= '0;
                            state     <= ST_IDLE;
                        end else begin
                            cam_write_enable <= 1'b1;
                            cam_write_delete <= 1'b1;
                            cam_write_addr   <= flush_cnt[ADDR_WIDTH-1:0];
                            cam_write_data   <= '0;
                            flush_cnt        <= flush_cnt + 1'b1;
                            wr_skip          <= 1'b1;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_learn_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mac_learn_ctrl
//   Drives mac_learn_ctrl against a behavioural cam_bram stand-in and checks
//   responses and CAM writes against an address-table reference model.
// ----------------------------------------------------------------------------
module tb_mac_learn_ctrl;

    localparam int unsigned MAC_WIDTH  = 48;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned PORT_WIDTH = 2;
    localparam int unsigned CAM_LAT    = 2;
    localparam int          DEPTH      = 32;

    logic                  clk;
    logic                  rst_n;
    logic                  req_valid;
    logic                  req_ready;
    logic [MAC_WIDTH-1:0]  req_src_mac;
    logic [MAC_WIDTH-1:0]  req_dst_mac;
    logic [PORT_WIDTH-1:0] req_port;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [PORT_WIDTH-1:0] resp_port;
    logic                  resp_flood;
    logic                  resp_drop;
    logic                  flush;
    logic                  flush_busy;
    logic [ADDR_WIDTH-1:0] cam_write_addr;
    logic [MAC_WIDTH-1:0]  cam_write_data;
    logic                  cam_write_delete;
    logic                  cam_write_enable;
    logic                  cam_write_busy;
    logic [MAC_WIDTH-1:0]  cam_compare_data;
    logic                  cam_match;
    logic [ADDR_WIDTH-1:0] cam_match_addr;

    mac_learn_ctrl #(
        .MAC_WIDTH  (MAC_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .PORT_WIDTH (PORT_WIDTH),
        .CAM_LAT    (CAM_LAT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_src_mac      (req_src_mac),
        .req_dst_mac      (req_dst_mac),
        .req_port         (req_port),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_port        (resp_port),
        .resp_flood       (resp_flood),
        .resp_drop        (resp_drop),
        .flush            (flush),
        .flush_busy       (flush_busy),
        .cam_write_addr   (cam_write_addr),
        .cam_write_data   (cam_write_data),
        .cam_write_delete (cam_write_delete),
        .cam_write_enable (cam_write_enable),
        .cam_write_busy   (cam_write_busy),
        .cam_compare_data (cam_compare_data),
        .cam_match        (cam_match),
        .cam_match_addr   (cam_match_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- cam_bram stand-in ----------------
    typedef struct {
        logic [4:0]  a;
        logic [47:0] d;
        logic        del;
    } wr_t;

    wr_t         wr_q[$];
    wr_t         pend_wr;
    logic [47:0] cam_mac [DEPTH];
    logic        cam_vld [DEPTH];
    logic        m0;
    logic [4:0]  a0;
    logic        busy_r;
    int          busy_cnt;
    logic        hold_busy;

    assign cam_write_busy = busy_r || hold_busy;

    function automatic logic [5:0] cam_lookup(input logic [47:0] m);
        for (int i = 0; i < DEPTH; i++) begin
            if (cam_vld[i] && cam_mac[i] == m) return {1'b1, 5'(i)};
        end
        return 6'd0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0             <= 1'b0;
            a0             <= '0;
            cam_match      <= 1'b0;
            cam_match_addr <= '0;
            busy_r         <= 1'b0;
            busy_cnt       <= 0;
            for (int i = 0; i < DEPTH; i++) cam_vld[i] <= 1'b0;
        end else begin
            {m0, a0}       <= cam_lookup(cam_compare_data);
            cam_match      <= m0;
            cam_match_addr <= a0;
            if (cam_write_enable) begin
                check_eq("we_while_busy", 64'(cam_write_busy), 64'd0);
                wr_q.push_back('{a: cam_write_addr, d: cam_write_data, del: cam_write_delete});
                pend_wr  <= '{a: cam_write_addr, d: cam_write_data, del: cam_write_delete};
                busy_r   <= 1'b1;
                busy_cnt <= 1 + int'($urandom_range(0, 2));
            end else if (busy_cnt != 0) begin
                if (busy_cnt == 1) begin
                    busy_r               <= 1'b0;
                    cam_vld[pend_wr.a]   <= !pend_wr.del;
                    cam_mac[pend_wr.a]   <= pend_wr.d;
                end
                busy_cnt <= busy_cnt - 1;
            end
        end
    end

    // ---------------- reference model: associative address table ----------------
    logic [47:0] ref_mac  [DEPTH];
    bit          ref_vld  [DEPTH];
    logic [1:0]  ref_port [DEPTH];
    int          ref_ptr;

    function automatic int ref_find(input logic [47:0] m);
        for (int i = 0; i < DEPTH; i++) begin
            if (ref_vld[i] && ref_mac[i] == m) return i;
        end
        return -1;
    endfunction

    function automatic bit group_addr(input logic [47:0] m);
        logic [7:0] first_octet;
        first_octet = m[47:40];
        return first_octet[0];
    endfunction

    task automatic ref_flush();
        for (int i = 0; i < DEPTH; i++) ref_vld[i] = 1'b0;
        ref_ptr = 0;
    endtask

    // One header through the DUT; resp_ready is held low for 'hold' cycles.
    task automatic do_req(input logic [47:0] s, input logic [47:0] d,
                          input logic [1:0] p, input int hold);
        int         idx;
        int         guard;
        bit         exp_wr;
        int         exp_addr;
        bit         exp_flood;
        bit         exp_drop;
        logic [1:0] exp_port;

        exp_wr   = 1'b0;
        exp_addr = 0;
        if (!group_addr(s)) begin
            idx = ref_find(s);
            if (idx < 0) begin
                exp_wr            = 1'b1;
                exp_addr          = ref_ptr;
                ref_mac[ref_ptr]  = s;
                ref_vld[ref_ptr]  = 1'b1;
                ref_port[ref_ptr] = p;
                ref_ptr           = (ref_ptr + 1) % DEPTH;
            end else begin
                ref_port[idx] = p;
            end
        end
        exp_flood = 1'b1;
        exp_drop  = 1'b0;
        exp_port  = 2'd0;
        if (!group_addr(d)) begin
            idx = ref_find(d);
            if (idx >= 0) begin
                exp_flood = 1'b0;
                exp_port  = ref_port[idx];
                exp_drop  = (exp_port == p);
            end
        end

        wr_q.delete();
        @(negedge clk);
        req_valid   = 1'b1;
        req_src_mac = s;
        req_dst_mac = d;
        req_port    = p;
        guard = 0;
        while (!req_ready && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        check_eq("req_accept", 64'(req_ready), 64'd1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;

        guard = 0;
        while (!resp_valid && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check_eq("resp_valid", 64'(resp_valid), 64'd1);
        if (!resp_valid) return;
        check_eq("resp_flood", 64'(resp_flood), 64'(exp_flood));
        check_eq("resp_drop", 64'(resp_drop), 64'(exp_drop));
        if (!exp_flood) check_eq("resp_port", 64'(resp_port), 64'(exp_port));

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("resp_hold", 64'({resp_valid, resp_flood, resp_drop, (exp_flood ? 2'd0 : resp_port)}),
                     64'({1'b1, exp_flood, exp_drop, exp_port}));
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check_eq("resp_clear", 64'(resp_valid), 64'd0);

        check_eq("wr_count", 64'(wr_q.size()), 64'(exp_wr));
        if (exp_wr && wr_q.size() >= 1) begin
            check_eq("wr_addr", 64'(wr_q[0].a), 64'(exp_addr));
            check_eq("wr_data", 64'(wr_q[0].d), 64'(s));
            check_eq("wr_del", 64'(wr_q[0].del), 64'd0);
        end
        if (group_addr(d)) check_eq("no_dst_cmp", 64'(cam_compare_data), 64'(s));
    endtask

    // ---------------- stimulus ----------------
    logic [47:0] mac_a, mac_b, mac_c, mac_first;
    logic [47:0] pool [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got time limit reached, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        mac_a = 48'h0011_2233_4455;
        mac_b = 48'h6677_8899_aabb;
        mac_c = 48'h0200_0000_0c0c;
        for (int i = 0; i < 6; i++) pool[i] = {16'h0a00, 32'(i) * 32'h0101_0101};
        pool[6] = 48'hffff_ffff_ffff;
        pool[7] = 48'h0100_5e00_0001;
        ref_flush();

        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_src_mac = '0;
        req_dst_mac = '0;
        req_port    = '0;
        resp_ready  = 1'b0;
        flush       = 1'b0;
        hold_busy   = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_outs", 64'({req_ready, resp_valid, resp_port, resp_flood, resp_drop,
                                  flush_busy, cam_write_enable, cam_write_delete, cam_write_addr}), 64'd0);
        check_eq("rst_cmp", 64'(cam_compare_data), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_ready", 64'(req_ready), 64'd1);
        check_eq("idle_flush_busy", 64'(flush_busy), 64'd0);

        // learn, reverse lookup, station move, drop
        do_req(mac_a, mac_b, 2'd1, 0);
        do_req(mac_b, mac_a, 2'd2, 0);
        do_req(mac_a, mac_b, 2'd3, 0);
        do_req(mac_c, mac_a, 2'd0, 0);
        do_req(mac_c, mac_c, 2'd0, 0);
        // broadcast destination, multicast source
        do_req(mac_a, 48'hffff_ffff_ffff, 2'd3, 0);
        do_req(48'h0100_5e00_0001, mac_b, 2'd1, 0);

        // busy held through LEARN: write must wait, then a single pulse
        fork
            do_req(48'h0200_0000_beef, mac_a, 2'd2, 0);
            begin
                repeat (2) @(negedge clk);
                hold_busy = 1'b1;
                repeat (10) @(negedge clk);
                check_eq("held_no_we", 64'(wr_q.size()), 64'd0);
                hold_busy = 1'b0;
            end
        join

        // response held for 5 cycles
        do_req(mac_b, mac_c, 2'd1, 5);

        for (int n = 0; n < 60; n++) begin
            do_req(pool[$urandom_range(0, 7)], pool[$urandom_range(0, 7)],
                   2'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        // flush during a request
        fork
            do_req(mac_a, mac_b, 2'd0, 0);
            begin
                repeat (4) @(negedge clk);
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
                check_eq("flush_pend", 64'(flush_busy), 64'd1);
            end
        join
        wr_q.delete();
        guard = 0;
        while (flush_busy && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check_eq("flush_done", 64'(flush_busy), 64'd0);
        check_eq("flush_cnt", 64'(wr_q.size()), 64'd32);
        for (int i = 0; i < 32 && i < wr_q.size(); i++) begin
            check_eq("flush_addr", 64'(wr_q[i].a), 64'(i));
            check_eq("flush_del", 64'(wr_q[i].del), 64'd1);
        end
        ref_flush();
        do_req(pool[1], mac_a, 2'd0, 0);

        // wrap: 33 new stations, the 33rd overwrites the oldest
        mac_first = 48'h0200_a000_0000;
        for (int i = 1; i < 33; i++) begin
            do_req(mac_first + 48'(i), 48'hffff_ffff_ffff, 2'(i), 0);
        end
        do_req(mac_first + 48'd33, 48'hffff_ffff_ffff, 2'd1, 0);
        if (wr_q.size() >= 1) check_eq("wrap_addr", 64'(wr_q[0].a), 64'd1);
        do_req(mac_first + 48'd40, mac_first + 48'd1, 2'd2, 0);
        do_req(mac_first + 48'd41, mac_first + 48'd2, 2'd0, 0);

        // reset in the middle of a flush
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("mid_flush_busy", 64'(flush_busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_outs", 64'({req_ready, resp_valid, resp_port, resp_flood, resp_drop,
                                        flush_busy, cam_write_enable, cam_write_delete, cam_write_addr}), 64'd0);
        check_eq("async_rst_data", 64'(cam_write_data), 64'd0);
        check_eq("async_rst_cmp", 64'(cam_compare_data), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
